// File: rtl/dot_operand_loader.sv
// dot_operand_loader: packs serial (pixel, weight) pairs into lane vectors for DotProduct.
// A fill buffer and an output register let the next vector load while the current one is held.
module dot_operand_loader #(
  parameter int N     = 10,
  parameter int PIX_W = 10,
  parameter int WGT_W = 19
) (
  input  logic                 clk,
  input  logic                 GlobalReset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PIX_W-1:0]     in_pixel,
  input  logic [WGT_W-1:0]     in_weight,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N*PIX_W-1:0]   Pixels,
  output logic [N*WGT_W-1:0]   Weights,
  output logic [15:0]          vec_count
);
  localparam int LW = $clog2(N);
  typedef enum logic {FILLING, FULL} state_t;
  state_t             state_q, state_d;
  logic [LW-1:0]      lane_q, lane_d;
  logic [N*PIX_W-1:0] fpix_q, fpix_d, mpix, pix_q, pix_d;
  logic [N*WGT_W-1:0] fwgt_q, fwgt_d, mwgt, wgt_q, wgt_d;
  logic               out_valid_q, out_valid_d;
  logic [15:0]        cnt_q, cnt_d;
  logic               fill_full, acc, take, free, complete, load;
  assign acc      = in_valid && in_ready;
  assign take     = out_valid_q && out_ready;
  assign free     = !out_valid_q || out_ready;
  assign complete = acc && (lane_q == LW'(N-1) || in_last);
  assign load     = free && (fill_full || complete);
  // Fill buffer with the lane being accepted this cycle merged in
  for (genvar k = 0; k < N; k++) begin : g_lane
    assign mpix[k*PIX_W +: PIX_W] = (acc && lane_q == LW'(k)) ? in_pixel  : fpix_q[k*PIX_W +: PIX_W];
    assign mwgt[k*WGT_W +: WGT_W] = (acc && lane_q == LW'(k)) ? in_weight : fwgt_q[k*WGT_W +: WGT_W];
  end
  always_ff @(posedge clk or negedge GlobalReset) begin
    if (!GlobalReset) state_q <= FILLING;
    else              state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    if (state_q == FILLING) state_d = (complete && !free) ? FULL : FILLING;
    else                    state_d = free ? FILLING : FULL;
  end
  always_comb begin
    fill_full = (state_q == FULL);
    in_ready  = !fill_full;
  end
  always_comb begin
    lane_d      = complete ? '0 : acc ? lane_q + 1'b1 : lane_q;
    fpix_d      = load ? '0 : mpix;
    fwgt_d      = load ? '0 : mwgt;
    pix_d       = load ? mpix : pix_q;
    wgt_d       = load ? mwgt : wgt_q;
    out_valid_d = load || (out_valid_q && !out_ready);
    cnt_d       = cnt_q + {15'd0, take};
  end
  always_ff @(posedge clk or negedge GlobalReset) begin
    if (!GlobalReset) begin
      lane_q      <= '0;
      fpix_q      <= '0;
      fwgt_q      <= '0;
      pix_q       <= '0;
      wgt_q       <= '0;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      lane_q      <= lane_d;
      fpix_q      <= fpix_d;
      fwgt_q      <= fwgt_d;
      pix_q       <= pix_d;
      wgt_q       <= wgt_d;
      out_valid_q <= out_valid_d;
      cnt_q       <= cnt_d;
    end
  end
  assign out_valid = out_valid_q;
  assign Pixels    = pix_q;
  assign Weights   = wgt_q;
  assign vec_count = cnt_q;
endmodule

// File: tb/tb_dot_operand_loader.sv
// tb_dot_operand_loader: directed stimulus with a vector scoreboard checked by a separate monitor.
module tb_dot_operand_loader;
  logic         clk, GlobalReset, in_valid, in_ready, in_last, out_valid, out_ready;
  logic [9:0]   in_pixel;
  logic [18:0]  in_weight;
  logic [99:0]  Pixels;
  logic [189:0] Weights;
  logic [15:0]  vec_count;
  dot_operand_loader dut (
    .clk(clk), .GlobalReset(GlobalReset), .in_valid(in_valid), .in_ready(in_ready),
    .in_pixel(in_pixel), .in_weight(in_weight), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .Pixels(Pixels), .Weights(Weights), .vec_count(vec_count)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  int           n_chk = 0, n_fail = 0, acc_n = 0, ml = 0;
  logic [99:0]  mp = '0, hp = '0;
  logic [189:0] mw = '0, hw = '0;
  logic [99:0]  qp[$];
  logic [189:0] qw[$];
  logic [15:0]  exp_cnt = 0;
  bit           held = 0;
  task automatic check(input string nm, input logic [255:0] a, input logic [255:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask
  task automatic send(input logic [9:0] p, input logic [18:0] w, input bit last);
    int t = 0;
    @(negedge clk);
    in_valid = 1; in_pixel = p; in_weight = w; in_last = last;
    while (!in_ready && t < 200) begin @(negedge clk); t++; end
    if (!in_ready) begin
      n_chk++; n_fail++;
      $display("FAIL accept timeout: in_ready stuck 0, required 1");
    end
    @(posedge clk);
    mp[ml*10 +: 10] = p;
    mw[ml*19 +: 19] = w;
    acc_n++;
    if (ml == 9 || last) begin
      qp.push_back(mp); qw.push_back(mw);
      mp = '0; mw = '0; ml = 0;
    end else ml++;
    #1 in_valid = 0; in_last = 0;
  endtask
  initial forever begin
    @(negedge clk); #1;
    if (GlobalReset) begin
      if (held) begin
        check("hold pixels", Pixels, hp);
        check("hold weights", Weights, hw);
        check("hold valid", out_valid, 1);
      end
      check("vec_count", vec_count, exp_cnt);
      held = out_valid && !out_ready; hp = Pixels; hw = Weights;
      if (out_valid && out_ready) begin
        if (qp.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected vector: got pixels %0h, required none", Pixels);
        end else begin
          check("vector pixels", Pixels, qp.pop_front());
          check("vector weights", Weights, qw.pop_front());
        end
        exp_cnt++;
      end
    end
  end
  initial begin
    GlobalReset = 0; in_valid = 0; in_pixel = 0; in_weight = 0; in_last = 0; out_ready = 0;
    #2;
    check("reset out_valid", out_valid, 0);
    check("reset pixels", Pixels, 0);
    check("reset weights", Weights, 0);
    check("reset vec_count", vec_count, 0);
    check("reset in_ready", in_ready, 1);
    @(negedge clk); GlobalReset = 1;
    out_ready = 1;
    for (int k = 0; k < 10; k++) send(10'(k), 19'h10000, 0);
    check("basic latency", out_valid, 1);
    check("basic lane3 pixel", Pixels[39:30], 3);
    check("basic lane9 pixel", Pixels[99:90], 9);
    check("basic lane0 weight", Weights[18:0], 19'h10000);
    check("basic lane9 weight", Weights[189:171], 19'h10000);
    @(posedge clk); #1;
    check("basic vec_count", vec_count, 1);
    for (int k = 0; k < 4; k++) send(10'(k + 1), 19'(k + 1), k == 3);
    check("short valid", out_valid, 1);
    check("short lanes 0-3", Pixels[39:0], {10'd4, 10'd3, 10'd2, 10'd1});
    check("short pixel pad", Pixels[99:40], 0);
    check("short weight pad", Weights[189:76], 0);
    send(10'h3FF, 19'h7FFFF, 1);
    check("restart lane0", Pixels, {90'd0, 10'h3FF});
    repeat (2) @(negedge clk);
    out_ready = 0; acc_n = 0;
    fork
      for (int i = 0; i < 25; i++) send(10'(i + 20), 19'(i * 7), i == 24);
      begin
        int t = 0;
        while (acc_n < 20 && t < 500) begin @(negedge clk); t++; end
        check("bp reach 20", acc_n, 20);
        check("bp in_ready drop", in_ready, 0);
        repeat (5) @(negedge clk);
        check("bp stalled", acc_n, 20);
        check("bp held lane0", Pixels[9:0], 20);
        out_ready = 1;
      end
    join
    repeat (3) @(negedge clk);
    check("bp vec_count", vec_count, 6);
    out_ready = 0;
    for (int k = 0; k < 19; k++) send(10'(500 + k), 19'(k), 0);
    out_ready = 1;
    send(10'd600, 19'd1234, 0);
    check("no bubble valid", out_valid, 1);
    check("no bubble lane0", Pixels[9:0], 510);
    check("no bubble lane9", Pixels[99:90], 600);
    for (int i = 0; i < 30; i++) send(10'(100 + i), 19'(i * 3), 0);
    repeat (3) @(negedge clk);
    check("b2b vec_count", vec_count, 11);
    for (int k = 0; k < 6; k++) send(10'(50 + k), 19'(k), 0);
    #1 GlobalReset = 0;
    ml = 0; mp = '0; mw = '0; exp_cnt = 0;
    #1;
    check("midreset out_valid", out_valid, 0);
    check("midreset pixels", Pixels, 0);
    check("midreset weights", Weights, 0);
    check("midreset vec_count", vec_count, 0);
    check("midreset in_ready", in_ready, 1);
    @(negedge clk); GlobalReset = 1;
    for (int k = 0; k < 10; k++) send(10'(9 - k), 19'(k), 0);
    check("postreset lane0", Pixels[9:0], 9);
    check("postreset lane9", Pixels[99:90], 0);
    check("postreset lane8", Pixels[89:80], 1);
    for (int i = 0; i < 65534; i++) send(10'(i), 19'(i), 1);
    repeat (2) @(negedge clk);
    check("count at max", vec_count, 16'hFFFF);
    send(10'd77, 19'd88, 1);
    repeat (2) @(negedge clk);
    check("count wrap", vec_count, 0);
    check("scoreboard drained", qp.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
